// File: rtl/block_ram_dual_be.sv
// ---------------------------------------------------------------------------
// block_ram_dual_be
//   Simple dual-port block RAM (one write port, one read port, one clock)
//   with per-byte write enables, selectable read-during-write behaviour,
//   an optional output register and a one-cycle read-valid strobe.
//
// Ports
//   CLK      : clock, all state updates on the rising edge
//   RST_N    : asynchronous active-low reset (clears read pipeline only)
//   WR_ADDR  : write address
//   DI       : write data
//   WE       : per-lane write enable, bit b covers DI[b*BYTE_WIDTH +: BYTE_WIDTH]
//   RD_ADDR  : read address
//   RE       : read enable
//   DO       : read data, holds its value until the next read completes
//   DO_VALID : high for one cycle when DO carries a new read result
// ---------------------------------------------------------------------------
module block_ram_dual_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 1,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = "UNUSED"
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [ADDR_WIDTH-1:0]               WR_ADDR,
  input  logic [DATA_WIDTH-1:0]               DI,
  input  logic [(DATA_WIDTH/BYTE_WIDTH)-1:0]  WE,
  input  logic [ADDR_WIDTH-1:0]               RD_ADDR,
  input  logic                                RE,
  output logic [DATA_WIDTH-1:0]               DO,
  output logic                                DO_VALID
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Reject parameter combinations the lane logic cannot represent.
  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("block_ram_dual_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
      $error("block_ram_dual_be: RDW_MODE must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Time-zero contents: block RAM inference honours this initialisation
  // pattern, so the array powers up all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Byte-lane write port. Kept free of the async reset so the tools map it
  // onto a byte-enabled block RAM; reset only gates the write enable.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (WE[b]) begin
          mem[WR_ADDR][b*BYTE_WIDTH +: BYTE_WIDTH] <= DI[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  collide;

  // Collision mux sits outside the array: in new-data mode each enabled
  // lane is forwarded from DI, every other lane keeps the pre-write value.
  always_comb begin
    old_word = mem[RD_ADDR];
    collide  = RE && (|WE) && (RD_ADDR == WR_ADDR);
    rd_word  = old_word;
    if (RDW_MODE == 1 && collide) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (WE[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = DI[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] stage1_data_d, stage1_data_q;
  logic                  stage1_valid_d, stage1_valid_q;

  // Stage 1 captures the read result and holds it between reads.
  always_comb begin
    stage1_data_d  = RE ? rd_word : stage1_data_q;
    stage1_valid_d = RE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage1_data_q  <= '0;
      stage1_valid_q <= 1'b0;
    end else begin
      stage1_data_q  <= stage1_data_d;
      stage1_valid_q <= stage1_valid_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] do_data_d, do_data_q;
      logic                  do_valid_d, do_valid_q;

      // Second stage only advances when stage 1 holds a fresh result, so a
      // result dropped by reset never reaches the output.
      always_comb begin
        do_data_d  = stage1_valid_q ? stage1_data_q : do_data_q;
        do_valid_d = stage1_valid_q;
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          do_data_q  <= '0;
          do_valid_q <= 1'b0;
        end else begin
          do_data_q  <= do_data_d;
          do_valid_q <= do_valid_d;
        end
      end

      assign DO       = do_data_q;
      assign DO_VALID = do_valid_q;
    end else begin : g_no_out_reg
      assign DO       = stage1_data_q;
      assign DO_VALID = stage1_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_dual_be.sv
// ---------------------------------------------------------------------------
// tb_block_ram_dual_be
//   Three instances share one stimulus stream:
//     dut_a : RDW_MODE=1, OUT_REG=0
//     dut_b : RDW_MODE=0, OUT_REG=0
//     dut_c : RDW_MODE=1, OUT_REG=1
//   A vector table drives writes, byte-enable merges, collisions, streaming
//   reads and address wrap; hand sequences cover reset behaviour.
// ---------------------------------------------------------------------------
module tb_block_ram_dual_be;

  logic        clk;
  logic        rst_n;
  logic [9:0]  wr_addr;
  logic [31:0] di;
  logic [3:0]  we;
  logic [9:0]  rd_addr;
  logic        re;

  logic [31:0] do_a, do_b, do_c;
  logic        vld_a, vld_b, vld_c;

  int n_compared;
  int n_mismatched;

  block_ram_dual_be #(.RDW_MODE(1), .OUT_REG(0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .WR_ADDR(wr_addr), .DI(di), .WE(we),
    .RD_ADDR(rd_addr), .RE(re), .DO(do_a), .DO_VALID(vld_a)
  );

  block_ram_dual_be #(.RDW_MODE(0), .OUT_REG(0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .WR_ADDR(wr_addr), .DI(di), .WE(we),
    .RD_ADDR(rd_addr), .RE(re), .DO(do_b), .DO_VALID(vld_b)
  );

  block_ram_dual_be #(.RDW_MODE(1), .OUT_REG(1)) dut_c (
    .CLK(clk), .RST_N(rst_n), .WR_ADDR(wr_addr), .DI(di), .WE(we),
    .RD_ADDR(rd_addr), .RE(re), .DO(do_c), .DO_VALID(vld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic [9:0]  ra;
    logic        ren;
    logic [31:0] exp_a;
    logic        exp_va;
    logic [31:0] exp_b;
    logic        exp_vb;
    logic [31:0] exp_c;
    logic        exp_vc;
  } vec_t;

  vec_t vecs [22];

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic [9:0] wa, input logic [31:0] wd,
                                input logic [3:0] wen, input logic [9:0] ra,
                                input logic ren);
    wr_addr = wa;
    di      = wd;
    we      = wen;
    rd_addr = ra;
    re      = ren;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] ea, input logic va,
                           input logic [31:0] eb, input logic vb,
                           input logic [31:0] ec, input logic vc);
    check_output({tag, " do_a"},  do_a,  ea);
    check_output({tag, " vld_a"}, {31'd0, vld_a}, {31'd0, va});
    check_output({tag, " do_b"},  do_b,  eb);
    check_output({tag, " vld_b"}, {31'd0, vld_b}, {31'd0, vb});
    check_output({tag, " do_c"},  do_c,  ec);
    check_output({tag, " vld_c"}, {31'd0, vld_c}, {31'd0, vc});
  endtask

  function automatic vec_t mk(input logic [9:0] wa, input logic [31:0] wd,
                              input logic [3:0] wen, input logic [9:0] ra,
                              input logic ren,
                              input logic [31:0] ea, input logic va,
                              input logic [31:0] eb, input logic vb,
                              input logic [31:0] ec, input logic vc);
    vec_t v;
    v.wa = wa; v.wd = wd; v.wen = wen; v.ra = ra; v.ren = ren;
    v.exp_a = ea; v.exp_va = va;
    v.exp_b = eb; v.exp_vb = vb;
    v.exp_c = ec; v.exp_vc = vc;
    return v;
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Expected values worked out by hand; dut_c lags dut_a by one cycle.
    //            wa      wd            we      ra      re    a             va    b             vb    c             vc
    vecs[0]  = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0);
    vecs[1]  = mk(10'd5,  32'hAABBCCDD, 4'hF,   10'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1);
    vecs[2]  = mk(10'd5,  32'h11223344, 4'h5,   10'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    vecs[3]  = mk(10'd0,  32'h0,        4'h0,   10'd5,  1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 32'h00000000, 1'b0);
    vecs[4]  = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b1);
    vecs[5]  = mk(10'd7,  32'h01020304, 4'hF,   10'd0,  1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0);
    vecs[6]  = mk(10'd7,  32'hFFFFFFFF, 4'h3,   10'd7,  1'b1, 32'h0102FFFF, 1'b1, 32'h01020304, 1'b1, 32'hAA22CC44, 1'b0);
    vecs[7]  = mk(10'd0,  32'h0,        4'h0,   10'd7,  1'b1, 32'h0102FFFF, 1'b1, 32'h0102FFFF, 1'b1, 32'h0102FFFF, 1'b1);
    vecs[8]  = mk(10'd0,  32'd10,       4'hF,   10'd0,  1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b1);
    vecs[9]  = mk(10'd1,  32'd11,       4'hF,   10'd0,  1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0);
    vecs[10] = mk(10'd2,  32'd12,       4'hF,   10'd0,  1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0);
    vecs[11] = mk(10'd3,  32'd13,       4'hF,   10'd0,  1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0, 32'h0102FFFF, 1'b0);
    vecs[12] = mk(10'd0,  32'h0,        4'h0,   10'd3,  1'b1, 32'd13,       1'b1, 32'd13,       1'b1, 32'h0102FFFF, 1'b0);
    vecs[13] = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b1, 32'd10,       1'b1, 32'd10,       1'b1, 32'd13,       1'b1);
    vecs[14] = mk(10'd0,  32'h0,        4'h0,   10'd1,  1'b1, 32'd11,       1'b1, 32'd11,       1'b1, 32'd10,       1'b1);
    vecs[15] = mk(10'd0,  32'h0,        4'h0,   10'd2,  1'b1, 32'd12,       1'b1, 32'd12,       1'b1, 32'd11,       1'b1);
    vecs[16] = mk(10'd0,  32'h0,        4'h0,   10'd3,  1'b1, 32'd13,       1'b1, 32'd13,       1'b1, 32'd12,       1'b1);
    vecs[17] = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b0, 32'd13,       1'b0, 32'd13,       1'b0, 32'd13,       1'b1);
    vecs[18] = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b0, 32'd13,       1'b0, 32'd13,       1'b0, 32'd13,       1'b0);
    vecs[19] = mk(10'h3FF,32'hDEADBEEF, 4'h8,   10'd0,  1'b0, 32'd13,       1'b0, 32'd13,       1'b0, 32'd13,       1'b0);
    vecs[20] = mk(10'd0,  32'h0,        4'h0,   10'h3FF,1'b1, 32'hDE000000, 1'b1, 32'hDE000000, 1'b1, 32'd13,       1'b0);
    vecs[21] = mk(10'd0,  32'h0,        4'h0,   10'd0,  1'b0, 32'hDE000000, 1'b0, 32'hDE000000, 1'b0, 32'hDE000000, 1'b1);

    // Reset held for 3 cycles with every enable asserted: nothing may move.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(10'd0, 32'hFFFFFFFF, 4'hF, 10'd0, 1'b1);
    end
    check_all("reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    wr_addr = '0; di = '0; we = '0; rd_addr = '0; re = 1'b0;
    rst_n = 1'b1;
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      apply_stimulus(vecs[i].wa, vecs[i].wd, vecs[i].wen, vecs[i].ra, vecs[i].ren);
      check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_va,
                vecs[i].exp_b, vecs[i].exp_vb, vecs[i].exp_c, vecs[i].exp_vc);
    end

    // Reset pulse between edge t and t+1 while dut_c has a read in stage 1.
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd3, 1'b1);
    check_all("midrst_t", 32'd13, 1'b1, 32'd13, 1'b1, 32'hDE000000, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("midrst_low", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b1;
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd0, 1'b0);
    check_all("midrst_t1", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd0, 1'b0);
    check_all("midrst_t2", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Array survives reset: a fresh read of addr 3 still returns 13.
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd3, 1'b1);
    check_all("reread_t", 32'd13, 1'b1, 32'd13, 1'b1, 32'h0, 1'b0);
    apply_stimulus(10'd0, 32'h0, 4'h0, 10'd0, 1'b0);
    check_all("reread_t1", 32'd13, 1'b0, 32'd13, 1'b0, 32'd13, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
